decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XZR_IDX, default 31, is the register index that reads as zero and never creates a hazard.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 if_valid  in  1 / if_instr  in  32 / if_pc  in  64: fetch offer (instruction, PC).
REQ-005 if_ready  out  1  decode accepts the fetch offer this cycle.
REQ-006 readReg1, readReg2  out  5 each: combinational read addresses to the register bank.
REQ-007 readData1, readData2  in  64 each: register bank read data, same cycle.
REQ-008 wbRegWrite  in  1 / wbWriteReg  in  5 / wbWriteData  in  64: writeback port snooped for bypass.
REQ-009 flush  in  1  taken branch in EX; discard decode contents.
REQ-010 ex_ready  in  1  EX accepts the ID/EX register.
REQ-011 ex_valid  out  1 / ex_pc  out  64 / ex_op1, ex_op2, ex_imm  out  64 each / ex_rd  out  5 / ex_alu  out  2 (00 ADD, 01 SUB, 10 AND, 11 ORR).
REQ-012 ex_regWrite, ex_memRead, ex_memWrite, ex_cbz, ex_b, ex_illegal  out  1 each: registered control bits.

Function
REQ-013 Decoding SHALL match the opcode field exactly: ADD [31:21]=10001011000; SUB 11001011000; AND 10001010000; ORR 10101010000; LDUR 11111000010; STUR 11111000000; CBZ [31:24]=10110100; B [31:26]=000101.
REQ-014 readReg1 SHALL be Rn [9:5]; readReg2 SHALL be Rm [20:16] for R-format, Rt [4:0] for STUR/CBZ.
REQ-015 An operand SHALL be zero when its index equals XZR_IDX, overriding bank data and bypass.
REQ-016 ex_imm SHALL be: LDUR/STUR sign-extended [20:12]; CBZ sign-extended [23:5] shifted left 2; B sign-extended [25:0] shifted left 2; otherwise 0.
REQ-017 ex_rd SHALL be [4:0]; ex_regWrite SHALL be 1 for R-format and LDUR only, and 0 when ex_rd equals XZR_IDX.
REQ-018 Any other encoding SHALL set ex_illegal=1 with all other control bits 0, and SHALL still advance.
REQ-019 Load-use stall SHALL be asserted when ex_valid, ex_memRead, ex_rd != XZR_IDX and ex_rd equals an operand index actually used by the decoding instruction.
REQ-020 if_ready SHALL equal !stall && !flush && (!ex_valid || ex_ready).
REQ-021 When (!ex_valid || ex_ready): ID/EX SHALL load the decoded instruction with ex_valid=1 if if_valid && if_ready, else SHALL load ex_valid=0 (bubble); otherwise ID/EX SHALL hold.
REQ-022 Latency SHALL be exactly one cycle from acceptance to ex_valid.
REQ-023 flush SHALL force ex_valid=0 next cycle regardless of ex_ready and SHALL accept nothing that cycle.
REQ-024 A stall SHALL last exactly one cycle for a single load-use pair; the instruction SHALL be accepted the following cycle.

Reset
REQ-025 rst_n=0 at a posedge SHALL clear ex_valid and every ex_* output to 0, overriding flush, stall and handshake.
REQ-026 if_ready SHALL be 0 while rst_n=0.

Configuration
REQ-027 With WB_BYPASS_EN defined, an operand whose index equals wbWriteReg with wbRegWrite=1 (index != XZR_IDX) SHALL take wbWriteData instead of bank data.
REQ-028 Without WB_BYPASS_EN, operands SHALL come from readData1/readData2 only, and the wb* ports SHALL be present but unused.

Verification
REQ-029 ADD X3,X1,X2 with bank X1=5, X2=7 -> next cycle ex_valid=1, ex_op1=5, ex_op2=7, ex_rd=3, ex_alu=00, ex_regWrite=1.
REQ-030 LDUR X4,[X1,#-8] then ADD X5,X4,X2 back-to-back -> LDUR issues; one bubble (ex_valid=0); ADD issues next cycle; if_ready=0 for exactly one cycle.
REQ-031 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, if_ready=0; on release the next instruction issues.
REQ-032 CBZ X9,#-4 (imm19 = all ones) -> ex_cbz=1, ex_imm=0xFFFF_FFFF_FFFF_FFFC, ex_op2 = X9 value, ex_regWrite=0.
REQ-033 With WB_BYPASS_EN: wbRegWrite=1, wbWriteReg=2, wbWriteData=0xAA while decoding SUB X1,X2,X31 -> ex_op1=0xAA, ex_op2=0. Without the macro -> ex_op1 = bank value.
REQ-034 flush and rst_n=0 asserted with if_valid=1 -> next cycle ex_valid=0; encoding 0xFFFFFFFF -> ex_illegal=1.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake: the fetch stage offers an instruction and its PC,
// and the decode stage answers with if_ready in the same cycle.
interface decode_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_ready;

  modport master (output if_valid, if_instr, if_pc, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

// File: rtl/decode_stage.sv
// Decode stage for a small ARMv8 subset: decodes the instruction, reads operands,
// detects load-use hazards and fills the ID/EX register.
// Optional writeback bypass of operands is enabled with the macro WB_BYPASS_EN.
module decode_stage #(
  parameter int unsigned XZR_IDX = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave fetch,
  output logic [4:0]    readReg1,
  output logic [4:0]    readReg2,
  input  logic [63:0]   readData1,
  input  logic [63:0]   readData2,
  input  logic          wbRegWrite,
  input  logic [4:0]    wbWriteReg,
  input  logic [63:0]   wbWriteData,
  input  logic          flush,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [63:0]   ex_pc,
  output logic [63:0]   ex_op1,
  output logic [63:0]   ex_op2,
  output logic [63:0]   ex_imm,
  output logic [4:0]    ex_rd,
  output logic [1:0]    ex_alu,
  output logic          ex_regWrite,
  output logic          ex_memRead,
  output logic          ex_memWrite,
  output logic          ex_cbz,
  output logic          ex_b,
  output logic          ex_illegal
);

  localparam logic [4:0] XZR = 5'(XZR_IDX);

  logic [31:0] instr;
  logic [10:0] opc;
  logic        is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_cbz, is_b;
  logic        is_r, is_legal, use_rn, use_r2;
  logic [4:0]  rn, rd;
  logic [63:0] op1, op2, imm;
  logic [1:0]  alu;
  logic [5:0]  ctl;
  logic        load_use, advance, accept;

  assign instr = fetch.if_instr;
  assign opc   = instr[31:21];
  assign rn    = instr[9:5];
  assign rd    = instr[4:0];

  assign is_add   = (opc == 11'b10001011000);
  assign is_sub   = (opc == 11'b11001011000);
  assign is_and   = (opc == 11'b10001010000);
  assign is_orr   = (opc == 11'b10101010000);
  assign is_ldur  = (opc == 11'b11111000010);
  assign is_stur  = (opc == 11'b11111000000);
  assign is_cbz   = (instr[31:24] == 8'b10110100);
  assign is_b     = (instr[31:26] == 6'b000101);
  assign is_r     = is_add | is_sub | is_and | is_orr;
  assign is_legal = is_r | is_ldur | is_stur | is_cbz | is_b;

  // STUR and CBZ carry their second source in the Rt field, not Rm.
  assign readReg1 = rn;
  assign readReg2 = (is_stur | is_cbz) ? rd : instr[20:16];

  assign use_rn = is_r | is_ldur | is_stur;
  assign use_r2 = is_r | is_stur | is_cbz;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    op1 = readData1;
    op2 = readData2;
`ifdef WB_BYPASS_EN
    if (wbRegWrite && wbWriteReg != XZR && wbWriteReg == readReg1) op1 = wbWriteData;
    if (wbRegWrite && wbWriteReg != XZR && wbWriteReg == readReg2) op2 = wbWriteData;
`endif
    if (readReg1 == XZR) op1 = '0;
    if (readReg2 == XZR) op2 = '0;
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = &{1'b0, wbRegWrite, wbWriteReg, wbWriteData};
`endif

  always_comb begin
    imm = '0;
    if (is_ldur || is_stur) imm = {{55{instr[20]}}, instr[20:12]};
    else if (is_cbz)        imm = {{43{instr[23]}}, instr[23:5], 2'b00};
    else if (is_b)          imm = {{36{instr[25]}}, instr[25:0], 2'b00};
  end

  always_comb begin
    alu = 2'b00;
    if (is_sub)      alu = 2'b01;
    else if (is_and) alu = 2'b10;
    else if (is_orr) alu = 2'b11;
  end

  // Control bits in output order: regWrite, memRead, memWrite, cbz, b, illegal.
  assign ctl = {(is_r | is_ldur) & (rd != XZR), is_ldur, is_stur, is_cbz, is_b, ~is_legal};

  assign load_use = ex_valid & ex_memRead & (ex_rd != XZR) &
                    ((use_rn & (ex_rd == readReg1)) | (use_r2 & (ex_rd == readReg2)));
  assign advance  = ~ex_valid | ex_ready;
  assign fetch.if_ready = rst_n & ~load_use & ~flush & advance;
  assign accept   = fetch.if_valid & fetch.if_ready;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  // flush implies accept=0, so a flush simply loads a bubble even when EX stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_alu      <= '0;
      {ex_regWrite, ex_memRead, ex_memWrite, ex_cbz, ex_b, ex_illegal} <= '0;
    end else if (flush || advance) begin
      ex_valid <= accept;
      {ex_regWrite, ex_memRead, ex_memWrite, ex_cbz, ex_b, ex_illegal} <= accept ? ctl : 6'b0;
      if (accept) begin
        ex_pc  <= fetch.if_pc;
        ex_op1 <= op1;
        ex_op2 <= op2;
        ex_imm <= imm;
        ex_rd  <= rd;
        ex_alu <= alu;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued when the
// fetch offer is accepted and compared one cycle later when the DUT issues.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [4:0]  readReg1, readReg2;
  logic [63:0] readData1, readData2;
  logic        wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic [63:0] wbWriteData;
  logic        flush, ex_ready;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_alu;
  logic        ex_regWrite, ex_memRead, ex_memWrite, ex_cbz, ex_b, ex_illegal;

  decode_stage_if fif ();

  decode_stage #(.XZR_IDX(31)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(fif),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2),
    .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu(ex_alu),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_cbz(ex_cbz), .ex_b(ex_b), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model; X31 holds junk that the DUT must never forward.
  logic [63:0] bank [32];
  always_comb begin
    readData1 = bank[readReg1];
    readData2 = bank[readReg2];
  end

  typedef struct {
    logic [63:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic [1:0]  alu;
    logic [5:0]  ctl;   // regWrite, memRead, memWrite, cbz, b, illegal
    bit          c1, c2;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp, last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000,
                          OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000,
                          OP_LDR = 11'b11111000010, OP_STR = 11'b11111000000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_fmt(logic [10:0] op, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
    return {op, rm, 6'b0, rn, rd};
  endfunction

  function automatic logic [31:0] d_fmt(logic [10:0] op, logic [8:0] im, logic [4:0] rn, logic [4:0] rt);
    return {op, im, 2'b00, rn, rt};
  endfunction

  function automatic exp_t mk(logic [63:0] pc, logic [63:0] op1, logic [63:0] op2, logic [63:0] imm,
                              logic [4:0] rd, logic [1:0] alu, logic [5:0] ctl, bit c1, bit c2);
    exp_t e;
    e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm;
    e.rd = rd; e.alu = alu; e.ctl = ctl; e.c1 = c1; e.c2 = c2;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("ex_pc", ex_pc, e.pc);
    if (e.c1) check("ex_op1", ex_op1, e.op1);
    if (e.c2) check("ex_op2", ex_op2, e.op2);
    check("ex_imm", ex_imm, e.imm);
    check("ex_rd", 64'(ex_rd), 64'(e.rd));
    check("ex_alu", 64'(ex_alu), 64'(e.alu));
    check("ex_ctl", 64'({ex_regWrite, ex_memRead, ex_memWrite, ex_cbz, ex_b, ex_illegal}), 64'(e.ctl));
  endtask

  // One clock: decide what the edge should do from settled inputs, then check it.
  task automatic tick(output bit acc);
    bit in_rst, in_flush, fresh, was_valid;
    #1;
    in_rst    = !rst_n;
    in_flush  = flush;
    acc       = fif.if_valid && fif.if_ready;
    if (in_rst)        check("rst.if_ready", 64'(fif.if_ready), 0);
    else if (in_flush) check("flush.if_ready", 64'(fif.if_ready), 0);
    fresh     = !in_rst && !in_flush && (!ex_valid || ex_ready);
    was_valid = ex_valid;
    if (acc) q.push_back(cur_exp);
    @(posedge clk);
    #1;
    if (in_rst || in_flush) check("kill.ex_valid", 64'(ex_valid), 0);
    else if (acc) begin
      check("issue.ex_valid", 64'(ex_valid), 1);
      last_exp = q.pop_front();
      compare(last_exp);
    end else if (fresh) check("bubble.ex_valid", 64'(ex_valid), 0);
    else if (was_valid) begin
      check("hold.ex_valid", 64'(ex_valid), 1);
      check("hold.ex_pc", ex_pc, last_exp.pc);
      check("hold.ex_imm", ex_imm, last_exp.imm);
      check("hold.ex_rd", 64'(ex_rd), 64'(last_exp.rd));
    end
  endtask

  // Offer one instruction until accepted; EX back-pressure for the first `hold` cycles.
  task automatic offer(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                       input exp_t e, input int hold, input int exp_stalls);
    int stalls = 0;
    bit done = 0;
    bit acc;
    fif.if_valid = 1'b1;
    fif.if_instr = ins;
    fif.if_pc    = pc;
    cur_exp      = e;
    for (int k = 0; k < 20 && !done; k++) begin
      ex_ready = (k >= hold);
      tick(acc);
      if (acc) done = 1;
      else stalls++;
    end
    fif.if_valid = 1'b0;
    ex_ready     = 1'b1;
    if (!done) check({"timeout.", tag}, 0, 1);
    check({"stalls.", tag}, 64'(stalls), 64'(stalls == exp_stalls ? stalls : exp_stalls));
  endtask

  initial begin : stim
    bit acc;
    logic [63:0] b9, byp1;
    for (int i = 0; i < 32; i++) bank[i] = 64'h1000 + 64'(i);
    bank[1]  = 64'd5;
    bank[2]  = 64'd7;
    bank[4]  = 64'h4444;
    bank[9]  = 64'h9999_0000_DEAD_BEEF;
    bank[31] = 64'hBAD0_BAD0_BAD0_BAD0;
    b9 = bank[9];

    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    wbRegWrite = 1'b0; wbWriteReg = '0; wbWriteData = '0;
    fif.if_valid = 1'b1; fif.if_instr = r_fmt(OP_ADD, 2, 1, 3); fif.if_pc = 64'h40;
    cur_exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick(acc);
    check("rst.data", ex_pc | ex_op1 | ex_op2 | ex_imm, 0);
    check("rst.ctl", 64'({ex_valid, ex_rd, ex_alu, ex_regWrite, ex_memRead, ex_memWrite,
                          ex_cbz, ex_b, ex_illegal}), 0);
    rst_n = 1'b1;
    fif.if_valid = 1'b0;
    tick(acc);

    // R-format stream, including XZR as source and destination
    offer("add", r_fmt(OP_ADD, 2, 1, 3),  64'h100, mk(64'h100, 5, 7, 0, 3, 2'b00, 6'b100000, 1, 1), 0, 0);
    offer("sub", r_fmt(OP_SUB, 2, 1, 6),  64'h104, mk(64'h104, 5, 7, 0, 6, 2'b01, 6'b100000, 1, 1), 0, 0);
    offer("and", r_fmt(OP_AND, 2, 9, 7),  64'h108, mk(64'h108, b9, 7, 0, 7, 2'b10, 6'b100000, 1, 1), 0, 0);
    offer("orr", r_fmt(OP_ORR, 31, 1, 8), 64'h10C, mk(64'h10C, 5, 0, 0, 8, 2'b11, 6'b100000, 1, 1), 0, 0);
    offer("add_xzr_rd", r_fmt(OP_ADD, 2, 1, 31), 64'h110, mk(64'h110, 5, 7, 0, 31, 2'b00, 6'b000000, 1, 1), 0, 0);

    // load-use on Rn: exactly one bubble
    offer("ldur", d_fmt(OP_LDR, 9'h1F8, 1, 4), 64'h200,
          mk(64'h200, 5, 0, 64'hFFFF_FFFF_FFFF_FFF8, 4, 2'b00, 6'b110000, 1, 0), 0, 0);
    offer("ldu_add", r_fmt(OP_ADD, 2, 4, 5), 64'h204, mk(64'h204, 64'h4444, 7, 0, 5, 2'b00, 6'b100000, 1, 1), 0, 1);
    offer("stur", d_fmt(OP_STR, 9'd16, 1, 2), 64'h208, mk(64'h208, 5, 7, 16, 2, 2'b00, 6'b001000, 1, 1), 0, 0);

    // load to XZR never stalls; load-use on STUR's Rt does
    offer("ldur_xzr", d_fmt(OP_LDR, 9'd0, 1, 31), 64'h300, mk(64'h300, 5, 0, 0, 31, 2'b00, 6'b010000, 1, 0), 0, 0);
    offer("xzr_add", r_fmt(OP_ADD, 2, 31, 5), 64'h304, mk(64'h304, 0, 7, 0, 5, 2'b00, 6'b100000, 1, 1), 0, 0);
    offer("ldur6", d_fmt(OP_LDR, 9'd0, 1, 6), 64'h308, mk(64'h308, 5, 0, 0, 6, 2'b00, 6'b110000, 1, 0), 0, 0);
    offer("ldu_stur", d_fmt(OP_STR, 9'd0, 1, 6), 64'h30C, mk(64'h30C, 5, 64'h1006, 0, 6, 2'b00, 6'b001000, 1, 1), 0, 1);

    // branches
    offer("cbz", {8'b10110100, 19'h7FFFF, 5'd9}, 64'h400,
          mk(64'h400, 0, b9, 64'hFFFF_FFFF_FFFF_FFFC, 9, 2'b00, 6'b000100, 0, 1), 0, 0);
    offer("b", {6'b000101, 26'd16}, 64'h404, mk(64'h404, 0, 0, 64'd64, 16, 2'b00, 6'b000010, 0, 0), 0, 0);

    // EX back-pressure for three cycles
    offer("hold_a", r_fmt(OP_ADD, 2, 1, 3), 64'h500, mk(64'h500, 5, 7, 0, 3, 2'b00, 6'b100000, 1, 1), 0, 0);
    offer("hold_b", r_fmt(OP_ORR, 31, 1, 8), 64'h504, mk(64'h504, 5, 0, 0, 8, 2'b11, 6'b100000, 1, 1), 3, 3);

    // writeback snoop
    wbRegWrite = 1'b1; wbWriteReg = 5'd2; wbWriteData = 64'hAA;
`ifdef WB_BYPASS_EN
    byp1 = 64'hAA;
`else
    byp1 = 64'd7;
`endif
    offer("bypass", r_fmt(OP_SUB, 31, 2, 1), 64'h600, mk(64'h600, byp1, 0, 0, 1, 2'b01, 6'b100000, 1, 1), 0, 0);
    wbRegWrite = 1'b0; wbWriteReg = '0; wbWriteData = '0;

    // illegal encodings still advance
    offer("ill_ones", 32'hFFFF_FFFF, 64'h700, mk(64'h700, 0, 0, 0, 31, 2'b00, 6'b000001, 0, 0), 0, 0);
    offer("ill_near", r_fmt(11'b10001011001, 2, 1, 3), 64'h704, mk(64'h704, 0, 0, 0, 3, 2'b00, 6'b000001, 0, 0), 0, 0);

    // flush with a live offer and EX stalled
    flush = 1'b1; ex_ready = 1'b0;
    fif.if_valid = 1'b1; fif.if_instr = r_fmt(OP_ADD, 2, 1, 3); fif.if_pc = 64'h800;
    tick(acc);
    check("flush.accept", 64'(acc), 0);
    flush = 1'b0; ex_ready = 1'b1; fif.if_valid = 1'b0;
    offer("post_flush", r_fmt(OP_ADD, 2, 1, 3), 64'h800, mk(64'h800, 5, 7, 0, 3, 2'b00, 6'b100000, 1, 1), 0, 0);

    // reset wins over flush and handshake
    rst_n = 1'b0; flush = 1'b1; ex_ready = 1'b0;
    fif.if_valid = 1'b1; fif.if_instr = d_fmt(OP_LDR, 9'd8, 1, 4); fif.if_pc = 64'h900;
    tick(acc);
    check("rst2.data", ex_pc | ex_op1 | ex_op2 | ex_imm, 0);
    check("rst2.ctl", 64'({ex_valid, ex_rd, ex_alu, ex_regWrite, ex_memRead, ex_memWrite,
                           ex_cbz, ex_b, ex_illegal}), 0);
    rst_n = 1'b1; flush = 1'b0; ex_ready = 1'b1; fif.if_valid = 1'b0;
    tick(acc);
    check("end.queue", 64'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
